multicycle_control_unit: RTL and testbench
==========================================

# multicycle_control_unit

Multi-cycle RV32I control unit for the multi-cycle core. It replaces the combinational decode of the single-cycle design with a registered state machine that steps each instruction through fetch, decode, execute, memory and writeback. It adds a ready/timeout handshake with instruction/data memory and a sticky trap state for illegal opcodes and memory timeouts. It sits between the instruction register and the shared-memory datapath multiplexers.

## Interface
- `TIMEOUT_W`, default 4: width of the memory-wait watchdog counter.
- `MAX_WAIT`, default 10: maximum cycles a memory state may wait for `mem_ready`. Must be < 2^TIMEOUT_W.
- `clk` in 1: clock.
- `rst` in 1: reset, **asynchronous, active-low**.
- `Op` in 7: opcode from the instruction register.
- `funct3` in 3: instruction bits [14:12].
- `funct7` in 7: instruction bits [31:25].
- `Zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory has completed the current access.
- `PCWrite` out 1: PC register enable.
- `AdrSrc` out 1: 0 = PC, 1 = ALU result, as the memory address.
- `MemWrite` out 1: memory write strobe.
- `IRWrite` out 1: instruction register and OldPC enable.
- `RegWrite` out 1: register file write.
- `ResultSrc` out 2: 00 ALUOut, 01 Data, 10 ALUResult.
- `ALUSrcA` out 2: 00 PC, 01 OldPC, 10 rs1.
- `ALUSrcB` out 2: 00 rs2, 01 Imm, 10 constant 4.
- `ImmSrc` out 2: 00 I, 01 S, 10 B, 11 J. Combinational from `Op`.
- `ALUControl` out 3: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- `instr_done` out 1: one-cycle pulse on the last cycle of each instruction.
- `trap` out 1: sticky error flag.
- `trap_cause` out 2: 00 none, 01 illegal opcode, 10 memory timeout.

## Operation
- **States:** FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, TRAP.
- **FETCH:** AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite and PCWrite are asserted only while `mem_ready`=1. Moves to DECODE on `mem_ready`.
- **DECODE:** ALUSrcA=01, ALUSrcB=01, ALUOp=00. Next state by `Op`:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BEQ
  - 1101111 → JAL
  - any other opcode → TRAP with cause 01
- **MEMADR:** ALUSrcA=10, ALUSrcB=01, ALUOp=00. Goes to MEMREAD if Op[5]=0, otherwise MEMWRITE.
- **MEMREAD:** AdrSrc=1, ResultSrc=00. Waits for `mem_ready`, then MEMWB.
- **MEMWB:** ResultSrc=01, RegWrite=1, then FETCH.
- **MEMWRITE:** AdrSrc=1, ResultSrc=00, MemWrite=1 held until `mem_ready`, then FETCH.
- **EXECR:** ALUSrcA=10, ALUSrcB=00, ALUOp=10, then ALUWB.
- **EXECI:** ALUSrcA=10, ALUSrcB=01, ALUOp=10, then ALUWB.
- **ALUWB:** ResultSrc=00, RegWrite=1, then FETCH.
- **BEQ:** ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00. PCWrite = `Zero`. Then FETCH.
- **JAL:** ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1, then ALUWB.
- **ALU decode:**
  - ALUOp 00 → add; 01 → sub.
  - ALUOp 10, funct3 000 → sub when {Op[5], funct7[5]}=11, otherwise add.
  - ALUOp 10, funct3 010 → slt; 110 → or; 111 → and; any other funct3 → add.
- **Watchdog:**
  - Counter clears on entry to FETCH, MEMREAD or MEMWRITE.
  - Increments each cycle that state waits with `mem_ready`=0.
  - On reaching MAX_WAIT with `mem_ready` still 0: go to TRAP, cause 10. No strobes are asserted in that cycle.
  - `mem_ready`=1 in the same cycle the count reaches MAX_WAIT counts as a completion, not a timeout.
- **TRAP:** all strobes 0 and `trap`=1. Left only by reset.
- **Unlisted outputs:** in every state, any output not listed above is 0.

## Timing
- Moore FSM; every output except the gated PCWrite/IRWrite is a function of the registered state (and `Op`/`funct*` for ImmSrc/ALUControl).
- Latency with `mem_ready` always 1:
  - R-type / I-type ALU / JAL: 4 cycles.
  - Branch: 3 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
- `instr_done` is asserted in MEMWB, ALUWB, BEQ, and in MEMWRITE when `mem_ready`=1.
- Reset values: state=FETCH, counter=0, `trap`=0, `trap_cause`=00. Outputs take FETCH values, with PCWrite=IRWrite=0 unless `mem_ready`=1.
- Reset asserted mid-instruction aborts immediately; no strobe survives into the reset cycle.

## Configuration
- `RV_JAL_EN` defined: the JAL state exists as described above.
- `RV_JAL_EN` undefined: opcode 1101111 goes to TRAP with cause 01. ImmSrc 11 is never produced; J-type decodes as 00.

## Structure
- Package `rv_ctrl_pkg` holds:
  - state enum;
  - opcode constants;
  - ALUControl, ResultSrc, ALUSrcA/B and ImmSrc encodings;
  - trap cause codes.
- One sub-module, `alu_ctrl_decode`: combinational ALUOp/funct3/funct7/Op → ALUControl. The FSM, watchdog and ImmSrc decode live in the top module.

## Test plan
- `add x3,x1,x2` (Op 0110011, funct3 000, funct7 0), `mem_ready`=1 → state sequence FETCH, DECODE, EXECR, ALUWB; ALUControl=000 in EXECR; RegWrite=1 and `instr_done`=1 in cycle 4.
- `lw` with `mem_ready` low for 3 cycles in MEMREAD → MemWrite=0 throughout, AdrSrc=1 for 4 cycles, RegWrite only in MEMWB; total 8 cycles.
- `beq` with Zero=1, then with Zero=0 → PCWrite=1 in BEQ only for Zero=1; ALUControl=001 in both cases.
- `sw` with `mem_ready` held 0 → TRAP after MAX_WAIT=10 waiting cycles, `trap_cause`=10, MemWrite drops to 0; only `rst`=0 recovers to FETCH.
- Op 1111111 → TRAP after DECODE, cause 01. With `RV_JAL_EN` undefined, Op 1101111 gives the same result; with it defined, the sequence is FETCH, DECODE, JAL, ALUWB.
- `rst` asserted while in MEMWRITE with `mem_ready`=0 → MemWrite=0 in the same cycle, state FETCH, `trap`=0.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control unit.
package rv_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMREAD,
      S_MEMWB,
      S_MEMWRITE,
      S_EXECR,
      S_EXECI,
      S_ALUWB,
      S_BEQ,
      S_JAL,
      S_TRAP
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   localparam logic [1:0] CAUSE_NONE    = 2'b00;
   localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

   // States that wait on mem_ready and are covered by the watchdog.
   function automatic logic is_mem_wait(input state_t s);
      return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
   endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALU control decode from ALUOp, funct3, funct7[5] and Op[5].
module alu_ctrl_decode
   import rv_ctrl_pkg::*;
(
   input  logic [1:0] alu_op,
   input  logic       op5,
   input  logic [2:0] funct3,
   input  logic       funct7_5,
   output logic [2:0] alu_control
);

   always_comb begin
      alu_control = ALU_ADD;
      case (alu_op)
         ALUOP_SUB: alu_control = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct3)
               // Only R-type (op5=1) can select sub; addi with funct7[5] set stays add.
               3'b000:  alu_control = (op5 & funct7_5) ? ALU_SUB : ALU_ADD;
               3'b010:  alu_control = ALU_SLT;
               3'b110:  alu_control = ALU_OR;
               3'b111:  alu_control = ALU_AND;
               default: alu_control = ALU_ADD;
            endcase
         end
         default: alu_control = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM with memory-wait watchdog and sticky trap.
// Optional JAL support is built when RV_JAL_EN is defined.
//
// state      | meaning
// FETCH      | read instruction at PC, PC <= PC+4 on mem_ready
// DECODE     | read registers, OldPC+imm into ALUOut
// MEMADR     | rs1+imm address for load/store
// MEMREAD    | load access, waits for mem_ready
// MEMWB      | write loaded data to rd
// MEMWRITE   | store access, MemWrite held until mem_ready
// EXECR      | R-type ALU operation
// EXECI      | I-type ALU operation
// ALUWB      | write ALUOut to rd
// BEQ        | compare rs1/rs2, PC <= target when Zero
// JAL        | PC <= target, OldPC+4 into ALUOut
// TRAP       | sticky error, left only by reset
module multicycle_control_unit
   import rv_ctrl_pkg::*;
#(
   parameter int TIMEOUT_W = 4,
   parameter int MAX_WAIT  = 10
)(
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] Op,
   input  logic [2:0] funct3,
   input  logic [6:0] funct7,
   input  logic       Zero,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ImmSrc,
   output logic [2:0] ALUControl,
   output logic       instr_done,
   output logic       trap,
   output logic [1:0] trap_cause
);

   localparam logic [TIMEOUT_W-1:0] MAX_CNT = TIMEOUT_W'(MAX_WAIT);

   state_t               state;
   logic [TIMEOUT_W-1:0] wait_cnt;
   logic                 timeout;
   logic [1:0]           alu_op;
   logic                 unused_funct7;

   assign unused_funct7 = ^{funct7[6], funct7[4:0]};

   // Timeout fires in the cycle the count sits at MAX_WAIT and memory is still busy.
   assign timeout = is_mem_wait(state) && !mem_ready && (wait_cnt == MAX_CNT);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_FETCH;
         wait_cnt   <= '0;
         trap       <= 1'b0;
         trap_cause <= CAUSE_NONE;
      end else begin
         // Held at zero outside a wait, so every wait state starts from zero.
         if (is_mem_wait(state) && !mem_ready && !timeout)
            wait_cnt <= wait_cnt + 1'b1;
         else
            wait_cnt <= '0;

         if (timeout) begin
            state      <= S_TRAP;
            trap       <= 1'b1;
            trap_cause <= CAUSE_TIMEOUT;
         end else begin
            case (state)
               S_FETCH:    if (mem_ready) state <= S_DECODE;
               S_DECODE: begin
                  case (Op)
                     OP_LOAD, OP_STORE: state <= S_MEMADR;
                     OP_RTYPE:          state <= S_EXECR;
                     OP_ITYPE:          state <= S_EXECI;
                     OP_BRANCH:         state <= S_BEQ;
`ifdef RV_JAL_EN
                     OP_JAL:            state <= S_JAL;
`endif
                     default: begin
                        state      <= S_TRAP;
                        trap       <= 1'b1;
                        trap_cause <= CAUSE_ILLEGAL;
                     end
                  endcase
               end
               S_MEMADR:   state <= Op[5] ? S_MEMWRITE : S_MEMREAD;
               S_MEMREAD:  if (mem_ready) state <= S_MEMWB;
               S_MEMWRITE: if (mem_ready) state <= S_FETCH;
               S_EXECR, S_EXECI, S_JAL: state <= S_ALUWB;
               S_MEMWB, S_ALUWB, S_BEQ: state <= S_FETCH;
               S_TRAP:     state <= S_TRAP;
               default:    state <= S_FETCH;
            endcase
         end
      end
   end

   always_comb begin
      PCWrite    = 1'b0;
      AdrSrc     = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      instr_done = 1'b0;
      ResultSrc  = RES_ALUOUT;
      ALUSrcA    = SRCA_PC;
      ALUSrcB    = SRCB_RS2;
      alu_op     = ALUOP_ADD;
      case (state)
         S_FETCH: begin
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALURESULT;
            PCWrite   = mem_ready;
            IRWrite   = mem_ready;
         end
         S_DECODE: begin
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_IMM;
         end
         S_MEMADR: begin
            ALUSrcA = SRCA_RS1;
            ALUSrcB = SRCB_IMM;
         end
         S_MEMREAD: AdrSrc = 1'b1;
         S_MEMWB: begin
            ResultSrc  = RES_DATA;
            RegWrite   = 1'b1;
            instr_done = 1'b1;
         end
         S_MEMWRITE: begin
            AdrSrc     = 1'b1;
            MemWrite   = !timeout;
            instr_done = mem_ready;
         end
         S_EXECR: begin
            ALUSrcA = SRCA_RS1;
            ALUSrcB = SRCB_RS2;
            alu_op  = ALUOP_FUNCT;
         end
         S_EXECI: begin
            ALUSrcA = SRCA_RS1;
            ALUSrcB = SRCB_IMM;
            alu_op  = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            RegWrite   = 1'b1;
            instr_done = 1'b1;
         end
         S_BEQ: begin
            ALUSrcA    = SRCA_RS1;
            ALUSrcB    = SRCB_RS2;
            alu_op     = ALUOP_SUB;
            PCWrite    = Zero;
            instr_done = 1'b1;
         end
         S_JAL: begin
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_FOUR;
            PCWrite = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      case (Op)
         OP_STORE:  ImmSrc = IMM_S;
         OP_BRANCH: ImmSrc = IMM_B;
`ifdef RV_JAL_EN
         OP_JAL:    ImmSrc = IMM_J;
`endif
         default:   ImmSrc = IMM_I;
      endcase
   end

   alu_ctrl_decode u_alu_ctrl_decode (
      .alu_op      (alu_op),
      .op5         (Op[5]),
      .funct3      (funct3),
      .funct7_5    (funct7[5]),
      .alu_control (ALUControl)
   );

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: directed cases then random instruction mix.
module tb_multicycle_control_unit;

   localparam int MAX_WAIT = 10;

   logic       clk;
   logic       rst;
   logic [6:0] op;
   logic [2:0] f3;
   logic [6:0] f7;
   logic       zero_in;
   logic       mem_ready;

   logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, instr_done, trap;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, trap_cause;
   logic [2:0] ALUControl;
   logic [19:0] obs;

   int vectors;
   int miscompares;
   logic [1:0] exp_cause;
   logic [6:0] illegal_ops [4];

   multicycle_control_unit #(.TIMEOUT_W(4), .MAX_WAIT(MAX_WAIT)) dut (
      .clk        (clk),
      .rst        (rst),
      .Op         (op),
      .funct3     (f3),
      .funct7     (f7),
      .Zero       (zero_in),
      .mem_ready  (mem_ready),
      .PCWrite    (PCWrite),
      .AdrSrc     (AdrSrc),
      .MemWrite   (MemWrite),
      .IRWrite    (IRWrite),
      .RegWrite   (RegWrite),
      .ResultSrc  (ResultSrc),
      .ALUSrcA    (ALUSrcA),
      .ALUSrcB    (ALUSrcB),
      .ImmSrc     (ImmSrc),
      .ALUControl (ALUControl),
      .instr_done (instr_done),
      .trap       (trap),
      .trap_cause (trap_cause)
   );

   assign obs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, instr_done, trap, trap_cause,
                 ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL global_timeout: simulation did not finish, vectors=%0d", vectors);
      $fatal(1);
   end

   function automatic logic rbit();
      return 1'($urandom_range(0, 1));
   endfunction

   // ALU result selected by an R/I arithmetic instruction.
   function automatic logic [2:0] arith_alu();
      logic is_sub;
      is_sub = (op == 7'b0110011) && f7[5];
      if (f3 == 3'b000) return is_sub ? 3'b001 : 3'b000;
      if (f3 == 3'b010) return 3'b101;
      if (f3 == 3'b110) return 3'b011;
      if (f3 == 3'b111) return 3'b010;
      return 3'b000;
   endfunction

   function automatic logic [1:0] imm_kind();
      if (op == 7'b0100011) return 2'b01;
      if (op == 7'b1100011) return 2'b10;
`ifdef RV_JAL_EN
      if (op == 7'b1101111) return 2'b11;
`endif
      return 2'b00;
   endfunction

   // Expected outputs for one cycle of the named phase.
   function automatic logic [19:0] exp_word(input string ph, input logic mr, input logic tmo);
      logic pcw, adr, mw, irw, rw, done, tr;
      logic [1:0] tc, rs, sa, sb;
      logic [2:0] alu;
      pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; done = 0; tr = 0;
      tc = 2'b00; rs = 2'b00; sa = 2'b00; sb = 2'b00; alu = 3'b000;
      case (ph)
         "F":    begin sb = 2'b10; rs = 2'b10; pcw = mr; irw = mr; end
         "D":    begin sa = 2'b01; sb = 2'b01; end
         "MA":   begin sa = 2'b10; sb = 2'b01; end
         "MR":   adr = 1;
         "MWB":  begin rs = 2'b01; rw = 1; done = 1; end
         "MW":   begin adr = 1; mw = !tmo; done = mr; end
         "XR":   begin sa = 2'b10; sb = 2'b00; alu = arith_alu(); end
         "XI":   begin sa = 2'b10; sb = 2'b01; alu = arith_alu(); end
         "WB":   begin rw = 1; done = 1; end
         "BEQ":  begin sa = 2'b10; alu = 3'b001; pcw = zero_in; done = 1; end
         "JAL":  begin sa = 2'b01; sb = 2'b10; pcw = 1; end
         "TRAP": begin tr = 1; tc = exp_cause; end
         default: ;
      endcase
      return {pcw, adr, mw, irw, rw, done, tr, tc, rs, sa, sb, imm_kind(), alu};
   endfunction

   task automatic chk(input logic [19:0] expv, input string tag);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed %05h expected %05h (op=%b f3=%b)", tag, obs, expv, op, f3);
      end
   endtask

   // Called at posedge+1; checks at the following negedge, returns at next posedge+1.
   task automatic step(input string ph, input logic mr, input logic tmo);
      mem_ready = mr;
      @(negedge clk);
      chk(exp_word(ph, mr, tmo), ph);
      @(posedge clk);
      #1;
   endtask

   // w busy cycles, then ready; more than MAX_WAIT busy cycles is a timeout.
   task automatic wait_phase(input string ph, input int w, output logic timed_out);
      timed_out = 1'b0;
      for (int k = 0; k <= MAX_WAIT; k++) begin
         if (k == w) begin
            step(ph, 1'b1, 1'b0);
            return;
         end else if (k == MAX_WAIT) begin
            step(ph, 1'b0, 1'b1);
            timed_out = 1'b1;
            return;
         end else begin
            step(ph, 1'b0, 1'b0);
         end
      end
   endtask

   task automatic do_reset(input logic mr);
      mem_ready = mr;
      rst = 1'b0;
      #1;
      chk(exp_word("F", mr, 1'b0), "reset");
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   task automatic enter_trap(input logic [1:0] cause);
      exp_cause = cause;
      repeat (3) step("TRAP", rbit(), 1'b0);
      do_reset(rbit());
   endtask

   task automatic run_instr(input logic [6:0] o, input logic [2:0] a3, input logic [6:0] a7,
                            input logic z, input int fw, input int mw);
      logic to;
      op = o; f3 = a3; f7 = a7; zero_in = z;
      wait_phase("F", fw, to);
      if (to) begin
         enter_trap(2'b10);
         return;
      end
      step("D", rbit(), 1'b0);
      case (o)
         7'b0000011: begin
            step("MA", rbit(), 1'b0);
            wait_phase("MR", mw, to);
            if (to) enter_trap(2'b10);
            else step("MWB", rbit(), 1'b0);
         end
         7'b0100011: begin
            step("MA", rbit(), 1'b0);
            wait_phase("MW", mw, to);
            if (to) enter_trap(2'b10);
         end
         7'b0110011: begin step("XR", rbit(), 1'b0); step("WB", rbit(), 1'b0); end
         7'b0010011: begin step("XI", rbit(), 1'b0); step("WB", rbit(), 1'b0); end
         7'b1100011: step("BEQ", rbit(), 1'b0);
`ifdef RV_JAL_EN
         7'b1101111: begin step("JAL", rbit(), 1'b0); step("WB", rbit(), 1'b0); end
`endif
         default: enter_trap(2'b01);
      endcase
   endtask

   initial begin
      logic [6:0] rop;
      int cls, fw, mw;
      vectors = 0;
      miscompares = 0;
      exp_cause = 2'b00;
      illegal_ops[0] = 7'b1111111;
      illegal_ops[1] = 7'b0000000;
      illegal_ops[2] = 7'b0110111;
      illegal_ops[3] = 7'b1100111;
      rst = 1'b0; op = 7'b0; f3 = 3'b0; f7 = 7'b0; zero_in = 1'b0; mem_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk(exp_word("F", 1'b0, 1'b0), "reset_init");
      rst = 1'b1;

      run_instr(7'b0110011, 3'b000, 7'h00, 1'b0, 0, 0);   // add
      run_instr(7'b0110011, 3'b000, 7'h20, 1'b0, 0, 0);   // sub
      run_instr(7'b0010011, 3'b000, 7'h20, 1'b0, 0, 0);   // addi, funct7[5] ignored
      run_instr(7'b0110011, 3'b111, 7'h00, 1'b0, 0, 0);   // and
      run_instr(7'b0010011, 3'b110, 7'h00, 1'b0, 0, 0);   // ori
      run_instr(7'b0110011, 3'b010, 7'h00, 1'b0, 0, 0);   // slt
      run_instr(7'b0000011, 3'b010, 7'h00, 1'b0, 0, 3);   // lw, 3 busy cycles
      run_instr(7'b1100011, 3'b000, 7'h00, 1'b1, 0, 0);   // beq taken
      run_instr(7'b1100011, 3'b000, 7'h00, 1'b0, 0, 0);   // beq not taken
      run_instr(7'b0100011, 3'b010, 7'h00, 1'b0, 0, 10);  // sw, ready at the limit
      run_instr(7'b0000011, 3'b010, 7'h00, 1'b0, 10, 0);  // fetch ready at the limit
      run_instr(7'b0100011, 3'b010, 7'h00, 1'b0, 0, 11);  // sw timeout
      run_instr(7'b1111111, 3'b000, 7'h00, 1'b0, 0, 0);   // illegal
      run_instr(7'b1101111, 3'b000, 7'h00, 1'b0, 0, 0);   // jal
      run_instr(7'b0000011, 3'b010, 7'h00, 1'b0, 12, 0);  // fetch timeout

      // Reset while a store is waiting on memory.
      op = 7'b0100011; f3 = 3'b010; f7 = 7'h00; zero_in = 1'b0;
      step("F", 1'b1, 1'b0);
      step("D", 1'b0, 1'b0);
      step("MA", 1'b0, 1'b0);
      step("MW", 1'b0, 1'b0);
      step("MW", 1'b0, 1'b0);
      mem_ready = 1'b0;
      #1;
      chk(exp_word("MW", 1'b0, 1'b0), "mw_before_rst");
      do_reset(1'b0);

      for (int n = 0; n < 60; n++) begin
         cls = $urandom_range(0, 7);
         case (cls)
            0:       rop = 7'b0000011;
            1:       rop = 7'b0100011;
            2, 7:    rop = 7'b0110011;
            3:       rop = 7'b0010011;
            4:       rop = 7'b1100011;
            5:       rop = 7'b1101111;
            default: rop = illegal_ops[$urandom_range(0, 3)];
         endcase
         fw = ($urandom_range(0, 15) == 0) ? $urandom_range(11, 13) : $urandom_range(0, 3);
         case ($urandom_range(0, 9))
            0:       mw = 10;
            1:       mw = 12;
            default: mw = $urandom_range(0, 4);
         endcase
         run_instr(rop, 3'($urandom_range(0, 7)), 7'($urandom_range(0, 127)), rbit(), fw, mw);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
